// File: rtl/ntt_ctrl.sv
// ntt_ctrl -- sequencing controller for the in-place forward NTT datapath.
//
// On a start pulse it walks the Kyber loop nest (len = N/2 down to 2, blocks
// of 2*len, butterflies j = blk..blk+len-1). It issues one butterfly per
// cycle: the read addresses (j+len, j) and the zeta index k. Every issue, or
// bubble, is pushed into a LAT-deep tag pipe. The pipe tail produces the
// write enables and addresses, so each write-back lines up with its
// butterfly result.
//
// Optional feature: define NTT_CTRL_LAYER_DRAIN_EN to insert a LAT-cycle
// DRAIN gap between layers. With the gap, the controller is hazard-free for
// any N >= 8. Without it, the next layer starts immediately. That is only
// correct when N/2 > LAT.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      transform request, sampled only in IDLE
//   hold       suppresses read issue this cycle (ISSUE only)
//   busy       high from accepted start until done
//   done       one-cycle completion pulse
//   r1_en/r1_addr, r2_en/r2_addr   read port enables / addresses (j+len, j)
//   zeta_addr  zeta ROM index k
//   bf_set     butterfly input valid (read issue delayed one cycle)
//   w1_en/w1_addr, w2_en/w2_addr   write-back enables / addresses (j+len, j)
module ntt_ctrl #(
    parameter int N   = 256,
    parameter int LAT = 4,
    parameter int AW  = $clog2(N),
    parameter int KW  = $clog2(N/2)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          hold,
    output logic          busy,
    output logic          done,
    output logic          r1_en,
    output logic [AW-1:0] r1_addr,
    output logic          r2_en,
    output logic [AW-1:0] r2_addr,
    output logic [KW-1:0] zeta_addr,
    output logic          bf_set,
    output logic          w1_en,
    output logic [AW-1:0] w1_addr,
    output logic          w2_en,
    output logic [AW-1:0] w2_addr
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FLUSH} state_t;

    localparam logic [AW-1:0] HALF_N = AW'(N / 2);
    localparam logic [AW:0]   N_W    = (AW+1)'(N);

    state_t        state_reg;
    logic [AW-1:0] len_reg;
    logic [AW-1:0] blk_reg;
    logic [AW-1:0] j_reg;
    logic [KW-1:0] k_reg;

`ifdef NTT_CTRL_LAYER_DRAIN_EN
    localparam int DW = $clog2(LAT + 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(LAT - 1);
    logic [DW-1:0] drain_cnt_reg;
`endif

    // Tag pipe: stage 0 is loaded on the issue edge, the tail feeds the
    // write registers, so a write appears exactly LAT cycles after its read.
    logic [LAT-1:0] tag_v_reg;
    logic [AW-1:0]  tag_j_reg   [LAT];
    logic [AW-1:0]  tag_len_reg [LAT];

    logic          issue_now;
    logic [AW:0]   blk_step;
    logic          block_end;
    logic          layer_end;

    assign issue_now = (state_reg == ISSUE) && !hold;
    // One bit wider so the "past the end of the polynomial" test cannot wrap.
    assign blk_step  = {1'b0, blk_reg} + {len_reg, 1'b0};
    assign block_end = (j_reg == (blk_reg + len_reg - AW'(1)));
    assign layer_end = block_end && (blk_step >= N_W);

    // Control FSM with registered read-side outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            r1_en         <= 1'b0;
            r2_en         <= 1'b0;
            r1_addr       <= '0;
            r2_addr       <= '0;
            zeta_addr     <= '0;
            len_reg       <= '0;
            blk_reg       <= '0;
            j_reg         <= '0;
            k_reg         <= '0;
`ifdef NTT_CTRL_LAYER_DRAIN_EN
            drain_cnt_reg <= '0;
`endif
        end else begin
            done  <= 1'b0;
            r1_en <= 1'b0;
            r2_en <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        len_reg   <= HALF_N;
                        blk_reg   <= '0;
                        j_reg     <= '0;
                        k_reg     <= KW'(1);
                        busy      <= 1'b1;
                        state_reg <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!hold) begin
                        r1_en     <= 1'b1;
                        r2_en     <= 1'b1;
                        r1_addr   <= j_reg + len_reg;
                        r2_addr   <= j_reg;
                        zeta_addr <= k_reg;
                        if (!block_end) begin
                            j_reg <= j_reg + AW'(1);
                        end else if (!layer_end) begin
                            k_reg   <= k_reg + KW'(1);
                            blk_reg <= blk_step[AW-1:0];
                            j_reg   <= blk_step[AW-1:0];
                        end else begin
                            k_reg <= k_reg + KW'(1);
                            if (len_reg == AW'(2)) begin
                                state_reg <= FLUSH;
                            end else begin
`ifdef NTT_CTRL_LAYER_DRAIN_EN
                                drain_cnt_reg <= '0;
                                state_reg     <= DRAIN;
`else
                                len_reg <= len_reg >> 1;
                                blk_reg <= '0;
                                j_reg   <= '0;
`endif
                            end
                        end
                    end
                end
                DRAIN: begin
`ifdef NTT_CTRL_LAYER_DRAIN_EN
                    // LAT idle cycles let the last write of this layer land
                    // before the first read of the next layer.
                    if (drain_cnt_reg == DRAIN_LAST) begin
                        len_reg   <= len_reg >> 1;
                        blk_reg   <= '0;
                        j_reg     <= '0;
                        state_reg <= ISSUE;
                    end else begin
                        drain_cnt_reg <= drain_cnt_reg + DW'(1);
                    end
`else
                    state_reg <= IDLE;
`endif
                end
                FLUSH: begin
                    if (tag_v_reg == '0) begin
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Tag pipe and write-back registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_v_reg <= '0;
            for (int i = 0; i < LAT; i++) begin
                tag_j_reg[i]   <= '0;
                tag_len_reg[i] <= '0;
            end
            bf_set  <= 1'b0;
            w1_en   <= 1'b0;
            w2_en   <= 1'b0;
            w1_addr <= '0;
            w2_addr <= '0;
        end else begin
            tag_v_reg      <= {tag_v_reg[LAT-2:0], issue_now};
            tag_j_reg[0]   <= j_reg;
            tag_len_reg[0] <= len_reg;
            for (int i = 1; i < LAT; i++) begin
                tag_j_reg[i]   <= tag_j_reg[i-1];
                tag_len_reg[i] <= tag_len_reg[i-1];
            end
            bf_set <= r1_en;
            w1_en  <= tag_v_reg[LAT-1];
            w2_en  <= tag_v_reg[LAT-1];
            // Bubbles leave the write addresses untouched.
            if (tag_v_reg[LAT-1]) begin
                w1_addr <= tag_j_reg[LAT-1] + tag_len_reg[LAT-1];
                w2_addr <= tag_j_reg[LAT-1];
            end
        end
    end

endmodule

// File: tb/tb_ntt_ctrl.sv
// tb_ntt_ctrl -- directed bench for ntt_ctrl (N=8 and N=256, LAT=4).
// Cycle c means "after the c-th rising edge", counting the edge that samples
// start as edge 0. Outputs are sampled on the falling edge.
module tb_ntt_ctrl;

    localparam int LAT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic       start8, hold8;
    logic       busy8, done8, r1_en8, r2_en8, bf_set8, w1_en8, w2_en8;
    logic [2:0] r1_addr8, r2_addr8, w1_addr8, w2_addr8;
    logic [1:0] zeta8;

    logic       start256, hold256;
    logic       busy256, done256, r1_en256, r2_en256, bf_set256, w1_en256, w2_en256;
    logic [7:0] r1_addr256, r2_addr256, w1_addr256, w2_addr256;
    logic [6:0] zeta256;

    ntt_ctrl #(.N(8), .LAT(LAT)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .hold(hold8),
        .busy(busy8), .done(done8),
        .r1_en(r1_en8), .r1_addr(r1_addr8), .r2_en(r2_en8), .r2_addr(r2_addr8),
        .zeta_addr(zeta8), .bf_set(bf_set8),
        .w1_en(w1_en8), .w1_addr(w1_addr8), .w2_en(w2_en8), .w2_addr(w2_addr8)
    );

    ntt_ctrl #(.N(256), .LAT(LAT)) dut256 (
        .clk(clk), .reset(reset), .start(start256), .hold(hold256),
        .busy(busy256), .done(done256),
        .r1_en(r1_en256), .r1_addr(r1_addr256), .r2_en(r2_en256), .r2_addr(r2_addr256),
        .zeta_addr(zeta256), .bf_set(bf_set256),
        .w1_en(w1_en256), .w1_addr(w1_addr256), .w2_en(w2_en256), .w2_addr(w2_addr256)
    );

    int checks   = 0;
    int failures = 0;

`ifdef NTT_CTRL_LAYER_DRAIN_EN
    localparam int DONE256 = 925;
`else
    localparam int DONE256 = 901;
`endif

    task automatic test_reset();
        reset = 1'b0; start8 = 1'b0; hold8 = 1'b0; start256 = 1'b0; hold256 = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy8, done8, r1_en8, r2_en8, bf_set8, w1_en8, w2_en8,
             r1_addr8, r2_addr8, zeta8, w1_addr8, w2_addr8} !== 21'd0) begin
            failures++;
            $display("FAIL reset_n8 got=%h exp=0", {busy8, done8, r1_en8, r2_en8, bf_set8,
                     w1_en8, w2_en8, r1_addr8, r2_addr8, zeta8, w1_addr8, w2_addr8});
        end
        checks++;
        if ({busy256, done256, r1_en256, r2_en256, bf_set256, w1_en256, w2_en256,
             r1_addr256, r2_addr256, zeta256, w1_addr256, w2_addr256} !== 46'd0) begin
            failures++;
            $display("FAIL reset_n256 got=%h exp=0", {busy256, done256, r1_en256, r2_en256,
                     bf_set256, w1_en256, w2_en256, r1_addr256, r2_addr256, zeta256,
                     w1_addr256, w2_addr256});
        end
        reset = 1'b1;
        @(negedge clk);
        $display("test_reset done");
    endtask

    // N=8 full address/zeta schedule with read, bf_set and write timing.
    task automatic test_sequence();
        int rc[8];
        int er1[8];
        int er2[8];
        int ek[8];
        int done_cyc;
        int nr;
        int nw;
        bit er, eb, ew;
`ifdef NTT_CTRL_LAYER_DRAIN_EN
        rc = '{1, 2, 3, 4, 9, 10, 11, 12};
        done_cyc = 17;
`else
        rc = '{1, 2, 3, 4, 5, 6, 7, 8};
        done_cyc = 13;
`endif
        er1 = '{4, 5, 6, 7, 2, 3, 6, 7};
        er2 = '{0, 1, 2, 3, 0, 1, 4, 5};
        ek  = '{1, 1, 1, 1, 2, 2, 3, 3};
        start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        nr = 0;
        nw = 0;
        for (int c = 0; c <= done_cyc + 2; c++) begin
            er = 1'b0; eb = 1'b0; ew = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (rc[i] == c)       er = 1'b1;
                if (rc[i] + 1 == c)   eb = 1'b1;
                if (rc[i] + LAT == c) ew = 1'b1;
            end
            checks++;
            if ({r1_en8, r2_en8, bf_set8, w1_en8, w2_en8} !== {er, er, eb, ew, ew}) begin
                failures++;
                $display("FAIL seq_enables c=%0d got=%b exp=%b", c,
                         {r1_en8, r2_en8, bf_set8, w1_en8, w2_en8}, {er, er, eb, ew, ew});
            end
            checks++;
            if ({busy8, done8} !== {(c < done_cyc), (c == done_cyc)}) begin
                failures++;
                $display("FAIL seq_busy_done c=%0d got=%b exp=%b", c, {busy8, done8},
                         {(c < done_cyc), (c == done_cyc)});
            end
            if (er && nr < 8) begin
                checks++;
                if ({r1_addr8, r2_addr8, zeta8} !== {3'(er1[nr]), 3'(er2[nr]), 2'(ek[nr])}) begin
                    failures++;
                    $display("FAIL seq_read c=%0d got=(%0d,%0d,%0d) exp=(%0d,%0d,%0d)", c,
                             r1_addr8, r2_addr8, zeta8, er1[nr], er2[nr], ek[nr]);
                end
                nr++;
            end
            if (ew && nw < 8) begin
                checks++;
                if ({w1_addr8, w2_addr8} !== {3'(er1[nw]), 3'(er2[nw])}) begin
                    failures++;
                    $display("FAIL seq_write c=%0d got=(%0d,%0d) exp=(%0d,%0d)", c,
                             w1_addr8, w2_addr8, er1[nw], er2[nw]);
                end
                nw++;
            end
            @(negedge clk);
        end
        $display("test_sequence reads=%0d writes=%0d", nr, nw);
    endtask

    // N=8 with hold high on edges 2..4: three read gaps, three write gaps.
    task automatic test_hold();
        int rc[8];
        int er1[8];
        int er2[8];
        int done_cyc;
        int nr;
        int nw;
        bit er, ew;
`ifdef NTT_CTRL_LAYER_DRAIN_EN
        rc = '{1, 5, 6, 7, 12, 13, 14, 15};
        done_cyc = 20;
`else
        rc = '{1, 5, 6, 7, 8, 9, 10, 11};
        done_cyc = 16;
`endif
        er1 = '{4, 5, 6, 7, 2, 3, 6, 7};
        er2 = '{0, 1, 2, 3, 0, 1, 4, 5};
        start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        nr = 0;
        nw = 0;
        for (int c = 0; c <= done_cyc + 2; c++) begin
            er = 1'b0; ew = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (rc[i] == c)       er = 1'b1;
                if (rc[i] + LAT == c) ew = 1'b1;
            end
            checks++;
            if ({r1_en8, w1_en8, done8} !== {er, ew, (c == done_cyc)}) begin
                failures++;
                $display("FAIL hold_ctrl c=%0d got=%b exp=%b", c, {r1_en8, w1_en8, done8},
                         {er, ew, (c == done_cyc)});
            end
            if (er && nr < 8) begin
                checks++;
                if ({r1_addr8, r2_addr8} !== {3'(er1[nr]), 3'(er2[nr])}) begin
                    failures++;
                    $display("FAIL hold_read c=%0d got=(%0d,%0d) exp=(%0d,%0d)", c,
                             r1_addr8, r2_addr8, er1[nr], er2[nr]);
                end
                nr++;
            end
            if (ew && nw < 8) begin
                checks++;
                if ({w1_addr8, w2_addr8} !== {3'(er1[nw]), 3'(er2[nw])}) begin
                    failures++;
                    $display("FAIL hold_write c=%0d got=(%0d,%0d) exp=(%0d,%0d)", c,
                             w1_addr8, w2_addr8, er1[nw], er2[nw]);
                end
                nw++;
            end
            if (c == 1) hold8 = 1'b1;
            if (c == 4) hold8 = 1'b0;
            @(negedge clk);
        end
        $display("test_hold reads=%0d writes=%0d", nr, nw);
    endtask

    // N=256 full run with stray start pulses while busy.
    task automatic test_n256_start_while_busy();
        int nr, nw, ndone, done_seen, busy_gap;
        int last_k, last_w1, last_w2;
        nr = 0; nw = 0; ndone = 0; done_seen = -1; busy_gap = 0;
        last_k = -1; last_w1 = -1; last_w2 = -1;
        start256 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start256 = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            if (r1_en256 && r2_en256) begin
                nr++;
                last_k = int'(zeta256);
            end
            if (w1_en256 && w2_en256) begin
                nw++;
                last_w1 = int'(w1_addr256);
                last_w2 = int'(w2_addr256);
            end
            if (done256) begin
                ndone++;
                if (done_seen < 0) done_seen = c;
            end
            if (done_seen < 0 && !busy256) busy_gap++;
            start256 = (c == 100 || c == 600);
            @(negedge clk);
        end
        start256 = 1'b0;
        checks++;
        if (nr !== 896) begin failures++; $display("FAIL n256_reads got=%0d exp=896", nr); end
        checks++;
        if (nw !== 896) begin failures++; $display("FAIL n256_writes got=%0d exp=896", nw); end
        checks++;
        if (last_k !== 127) begin failures++; $display("FAIL n256_last_k got=%0d exp=127", last_k); end
        checks++;
        if (last_w1 !== 255 || last_w2 !== 253) begin
            failures++;
            $display("FAIL n256_last_write got=(%0d,%0d) exp=(255,253)", last_w1, last_w2);
        end
        checks++;
        if (done_seen !== DONE256) begin
            failures++;
            $display("FAIL n256_done_cycle got=%0d exp=%0d", done_seen, DONE256);
        end
        checks++;
        if (ndone !== 1) begin failures++; $display("FAIL n256_done_count got=%0d exp=1", ndone); end
        checks++;
        if (busy_gap !== 0) begin failures++; $display("FAIL n256_busy_gap got=%0d exp=0", busy_gap); end
        checks++;
        if (busy256 !== 1'b0) begin failures++; $display("FAIL n256_busy_end got=%b exp=0", busy256); end
        $display("test_n256 reads=%0d writes=%0d done_cycle=%0d", nr, nw, done_seen);
    endtask

    // Reset at cycle 50 of an N=256 run, then a clean restart.
    task automatic test_reset_mid();
        int stray, done_seen, nw;
        stray = 0;
        start256 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start256 = 1'b0;
        for (int c = 0; c < 50; c++) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({busy256, done256, r1_en256, r2_en256, bf_set256, w1_en256, w2_en256,
             r1_addr256, r2_addr256, zeta256, w1_addr256, w2_addr256} !== 46'd0) begin
            failures++;
            $display("FAIL mid_reset_outputs got=%h exp=0", {busy256, done256, r1_en256,
                     r2_en256, bf_set256, w1_en256, w2_en256, r1_addr256, r2_addr256,
                     zeta256, w1_addr256, w2_addr256});
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 5) reset = 1'b1;
            if (w1_en256 || w2_en256 || r1_en256 || busy256) stray++;
        end
        checks++;
        if (stray !== 0) begin failures++; $display("FAIL mid_reset_stray got=%0d exp=0", stray); end
        start256 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start256 = 1'b0;
        done_seen = -1;
        nw = 0;
        for (int c = 0; c < 1000 && done_seen < 0; c++) begin
            if (w1_en256) nw++;
            if (done256) done_seen = c;
            @(negedge clk);
        end
        checks++;
        if (done_seen !== DONE256 || nw !== 896) begin
            failures++;
            $display("FAIL restart got done=%0d writes=%0d exp done=%0d writes=896",
                     done_seen, nw, DONE256);
        end
        $display("test_reset_mid restart done_cycle=%0d writes=%0d", done_seen, nw);
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_hold();
        test_n256_start_while_busy();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
